// File: rtl/alu_seq.sv
// rtl/alu_seq.sv - multi-cycle ALU with registered result, latched flags and start/busy/done handshake
// Single-cycle ops finish in one FIN cycle; shifts step one bit per cycle; MUL is LSB-first shift-add.
module alu_seq #(
   parameter int W   = 16,
   parameter int SHW = 4
) (
   input  logic         i_clk,
   input  logic         i_rst,
   input  logic         i_start,
   input  logic [3:0]   i_op,
   input  logic [W-1:0] i_a,
   input  logic [W-1:0] i_b,
   output logic         o_busy,
   output logic         o_done,
   output logic [W-1:0] o_x,
   output logic         o_we,
   output logic [3:0]   o_code,
   output logic         o_err
);

   localparam logic [3:0] OP_ADD = 4'b0000;
   localparam logic [3:0] OP_SUB = 4'b0001;
   localparam logic [3:0] OP_AND = 4'b0010;
   localparam logic [3:0] OP_OR  = 4'b0011;
   localparam logic [3:0] OP_XOR = 4'b0100;
   localparam logic [3:0] OP_CMP = 4'b0101;
   localparam logic [3:0] OP_MOV = 4'b0110;
   localparam logic [3:0] OP_MUL = 4'b0111;

   // Counter must hold both the largest shift count and W for MUL.
   localparam int CW = (SHW > $clog2(W + 1)) ? SHW : $clog2(W + 1);

   typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_MUL, ST_FIN} state_t;

   state_t         r_state;
   logic [CW-1:0]  r_cnt;
   logic [1:0]     r_dir;
   logic [W-1:0]   r_sh;
   logic [2*W-1:0] r_acc;
   logic [2*W-1:0] r_mcand;
   logic [W-1:0]   r_mplier;
   logic           r_busy;
   logic           r_done;
   logic           r_we;
   logic           r_err;
   logic [W-1:0]   r_x;
   logic [3:0]     r_code;

   logic [W:0]     w_sum;
   logic [W:0]     w_dif;
   logic [W-1:0]   w_res;
   logic           w_c;
   logic           w_v;
   logic           w_legal;
   logic           w_wr;
   logic           w_is_mul;
   logic           w_is_shift;
   logic [SHW-1:0] w_n;
   logic [W-1:0]   w_sh_next;
   logic           w_sh_out;
   logic [2*W-1:0] w_acc_next;
   logic [W-1:0]   w_prod_lo;
   logic [W-1:0]   w_prod_hi;

   assign w_sum      = {1'b0, i_a} + {1'b0, i_b};
   assign w_dif      = {1'b0, i_a} - {1'b0, i_b};
   assign w_is_mul   = (i_op == OP_MUL);
   assign w_is_shift = (i_op[3:2] == 2'b10);
   assign w_n        = i_b[SHW-1:0];

   always_comb begin
      w_res   = '0;
      w_c     = 1'b0;
      w_v     = 1'b0;
      w_legal = 1'b1;
      w_wr    = 1'b1;
      case (i_op)
         OP_ADD: begin
            w_res = w_sum[W-1:0];
            w_c   = w_sum[W];
            w_v   = (i_a[W-1] == i_b[W-1]) && (w_sum[W-1] != i_a[W-1]);
         end
         OP_SUB, OP_CMP: begin
            w_res = w_dif[W-1:0];
            w_c   = w_dif[W];
            w_v   = (i_a[W-1] != i_b[W-1]) && (w_dif[W-1] != i_a[W-1]);
            w_wr  = (i_op != OP_CMP);
         end
         OP_AND: w_res = i_a & i_b;
         OP_OR:  w_res = i_a | i_b;
         OP_XOR: w_res = i_a ^ i_b;
         OP_MOV: w_res = i_b;
         4'b1000, 4'b1001, 4'b1010, 4'b1011: w_res = i_a;
         default: begin
            w_legal = 1'b0;
            w_wr    = 1'b0;
         end
      endcase
   end

   always_comb begin
      w_sh_next = r_sh;
      w_sh_out  = 1'b0;
      case (r_dir)
         2'b00: begin
            w_sh_next = {r_sh[W-2:0], 1'b0};
            w_sh_out  = r_sh[W-1];
         end
         2'b01: begin
            w_sh_next = {r_sh[W-2:0], r_sh[W-1]};
            w_sh_out  = r_sh[W-1];
         end
         2'b10: begin
            w_sh_next = {1'b0, r_sh[W-1:1]};
            w_sh_out  = r_sh[0];
         end
         default: begin
            w_sh_next = {r_sh[W-1], r_sh[W-1:1]};
            w_sh_out  = r_sh[0];
         end
      endcase
   end

   assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
   assign w_prod_lo  = w_acc_next[W-1:0];
   assign w_prod_hi  = w_acc_next[2*W-1:W];

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state  <= ST_IDLE;
         r_cnt    <= '0;
         r_dir    <= 2'b00;
         r_sh     <= '0;
         r_acc    <= '0;
         r_mcand  <= '0;
         r_mplier <= '0;
         r_busy   <= 1'b0;
         r_done   <= 1'b0;
         r_we     <= 1'b0;
         r_err    <= 1'b0;
         r_x      <= '0;
         r_code   <= 4'b0000;
      end else begin
         r_done <= 1'b0;
         r_we   <= 1'b0;
         r_err  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (i_start) begin
                  r_busy <= 1'b1;
                  r_dir  <= i_op[1:0];
                  if (w_is_mul) begin
                     r_state  <= ST_MUL;
                     r_cnt    <= CW'(W);
                     r_acc    <= '0;
                     r_mcand  <= {{W{1'b0}}, i_a};
                     r_mplier <= i_b;
                  end else if (w_is_shift && (w_n != '0)) begin
                     r_state <= ST_SHIFT;
                     r_cnt   <= CW'(w_n);
                     r_sh    <= i_a;
                  end else begin
                     r_state <= ST_FIN;
                     r_done  <= 1'b1;
                     r_we    <= w_wr;
                     r_err   <= ~w_legal;
                     if (w_wr)
                        r_x <= w_res;
                     if (w_legal)
                        r_code <= {w_res[W-1], (w_res == '0), w_c, w_v};
                  end
               end
            end
            ST_SHIFT: begin
               r_sh  <= w_sh_next;
               r_cnt <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_state <= ST_FIN;
                  r_done  <= 1'b1;
                  r_we    <= 1'b1;
                  r_x     <= w_sh_next;
                  r_code  <= {w_sh_next[W-1], (w_sh_next == '0), w_sh_out, 1'b0};
               end
            end
            ST_MUL: begin
               r_acc    <= w_acc_next;
               r_mcand  <= {r_mcand[2*W-2:0], 1'b0};
               r_mplier <= {1'b0, r_mplier[W-1:1]};
               r_cnt    <= r_cnt - CW'(1);
               if (r_cnt == CW'(1)) begin
                  r_state <= ST_FIN;
                  r_done  <= 1'b1;
                  r_we    <= 1'b1;
                  r_x     <= w_prod_lo;
                  r_code  <= {w_prod_lo[W-1], (w_prod_lo == '0), (w_prod_hi != '0), 1'b0};
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign o_busy = r_busy;
   assign o_done = r_done;
   assign o_we   = r_we;
   assign o_err  = r_err;
   assign o_x    = r_x;
   assign o_code = r_code;

endmodule
